// File: rtl/multi_deque_pkg.sv
// Shared definitions for the multi-channel deque: opcodes and width helpers.
// Optional PEEK_FRONT/PEEK_BACK support is enabled by defining MULTI_DEQUE_PEEK_EN.
package multi_deque_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP        = 3'd0,
    OP_PUSH_BACK  = 3'd1,
    OP_PUSH_FRONT = 3'd2,
    OP_POP_FRONT  = 3'd3,
    OP_POP_BACK   = 3'd4,
    OP_PEEK_FRONT = 3'd5,
    OP_PEEK_BACK  = 3'd6,
    OP_RSVD       = 3'd7
  } op_t;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/deque_channel.sv
// One double-ended queue: circular buffer with head/tail pointers and a count.
// Strobes arrive pre-qualified (never push when full, never pop when empty).
module deque_channel #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_back_i,
  input  logic             push_front_i,
  input  logic             pop_front_i,
  input  logic             pop_back_i,
  input  logic             rd_back_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] head_m1, tail_m1;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en;
  logic [PTR_W-1:0] wr_addr;

  // Pointers wrap modulo DEPTH through natural overflow of the PTR_W-bit sum.
  assign head_m1 = head_q - PTR_W'(1);
  assign tail_m1 = tail_q - PTR_W'(1);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_addr = tail_q;
    if (push_back_i) begin
      wr_en   = 1'b1;
      wr_addr = tail_q;
      tail_d  = tail_q + PTR_W'(1);
      count_d = count_q + CNT_W'(1);
    end else if (push_front_i) begin
      wr_en   = 1'b1;
      wr_addr = head_m1;
      head_d  = head_m1;
      count_d = count_q + CNT_W'(1);
    end else if (pop_front_i) begin
      head_d  = head_q + PTR_W'(1);
      count_d = count_q - CNT_W'(1);
    end else if (pop_back_i) begin
      tail_d  = tail_m1;
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: the storage array has no reset; the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[wr_addr] <= data_i;
  end

  assign rd_data_o = rd_back_i ? mem_q[tail_m1] : mem_q[head_q];
  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/multi_deque.sv
// NUM_CH independent deques behind one op/channel port; registered data_out and pulses.
// Define MULTI_DEQUE_PEEK_EN to accept PEEK_FRONT/PEEK_BACK; otherwise codes 5-7 are rejected.
module multi_deque
  import multi_deque_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int NUM_CH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [OP_W-1:0]           op,
  input  logic [sel_w(NUM_CH)-1:0]  ch_sel,
  input  logic [WIDTH-1:0]          data_in,
  output logic [WIDTH-1:0]          data_out,
  output logic                      out_valid,
  output logic                      err,
  output logic [NUM_CH-1:0]         empty,
  output logic [NUM_CH-1:0]         full
);

  localparam int CH_W = sel_w(NUM_CH);

  logic             is_push_back, is_push_front, is_pop_front, is_pop_back, is_peek;
  logic             rd_back, bad_op, is_nop;
  logic             need_space, need_data, is_read;
  logic             ch_ok, reject, accept;
  logic [CH_W-1:0]  ch_idx;
  logic [WIDTH-1:0] rd_data [NUM_CH];

  logic [WIDTH-1:0] data_out_q;
  logic             out_valid_q, err_q;

  always_comb begin
    is_push_back  = 1'b0;
    is_push_front = 1'b0;
    is_pop_front  = 1'b0;
    is_pop_back   = 1'b0;
    is_peek       = 1'b0;
    rd_back       = 1'b0;
    bad_op        = 1'b0;
    is_nop        = 1'b0;
    case (op_t'(op))
      OP_NOP:        is_nop        = 1'b1;
      OP_PUSH_BACK:  is_push_back  = 1'b1;
      OP_PUSH_FRONT: is_push_front = 1'b1;
      OP_POP_FRONT:  is_pop_front  = 1'b1;
      OP_POP_BACK: begin
        is_pop_back = 1'b1;
        rd_back     = 1'b1;
      end
`ifdef MULTI_DEQUE_PEEK_EN
      OP_PEEK_FRONT: is_peek = 1'b1;
      OP_PEEK_BACK: begin
        is_peek = 1'b1;
        rd_back = 1'b1;
      end
`endif
      default:       bad_op = 1'b1;
    endcase
  end

  // Out-of-range channels are steered to channel 0 for lookups but always rejected.
  assign ch_ok  = (int'(ch_sel) < NUM_CH);
  assign ch_idx = ch_ok ? ch_sel : '0;

  assign need_space = is_push_back | is_push_front;
  assign is_read    = is_pop_front | is_pop_back | is_peek;
  assign need_data  = is_read;
  assign reject     = bad_op
                    | (!ch_ok && !is_nop)
                    | (need_space && full[ch_idx])
                    | (need_data  && empty[ch_idx]);
  assign accept     = !reject;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic hit;
    assign hit = accept && (ch_idx == CH_W'(i));

    deque_channel #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .push_back_i  (hit && is_push_back),
      .push_front_i (hit && is_push_front),
      .pop_front_i  (hit && is_pop_front),
      .pop_back_i   (hit && is_pop_back),
      .rd_back_i    (rd_back),
      .data_i       (data_in),
      .rd_data_o    (rd_data[i]),
      .empty_o      (empty[i]),
      .full_o       (full[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q       <= reject;
      out_valid_q <= accept && is_read;
      if (accept && is_read) data_out_q <= rd_data[ch_idx];
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_multi_deque.sv
// Scoreboard bench for multi_deque (NUM_CH=2, DEPTH=4): directed ops with hand-computed results.
// Expectations follow MULTI_DEQUE_PEEK_EN when the design is built with it.
module tb_multi_deque;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 4;
  localparam int NUM_CH = 2;

  typedef struct {
    logic             ov;
    logic             er;
    logic [WIDTH-1:0] dout;
    logic [1:0]       emp;
    logic [1:0]       ful;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [2:0]       op = 3'd0;
  logic [0:0]       ch_sel = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] data_out;
  logic             out_valid, err;
  logic [1:0]       empty, full;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  multi_deque #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_CH(NUM_CH)) dut (
    .clk       (clk),
    .rst       (rst),
    .op        (op),
    .ch_sel    (ch_sel),
    .data_in   (data_in),
    .data_out  (data_out),
    .out_valid (out_valid),
    .err       (err),
    .empty     (empty),
    .full      (full)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Drive one op on the falling edge and queue the response expected after the next rising edge.
  task automatic issue(input logic r, input logic [2:0] o, input int c, input logic [7:0] d,
                       input logic ev, input logic ee, input logic [7:0] ed,
                       input logic [1:0] emp, input logic [1:0] ful);
    exp_t e;
    @(negedge clk);
    rst     = r;
    op      = o;
    ch_sel  = c[0:0];
    data_in = d;
    e.ov = ev; e.er = ee; e.dout = ed; e.emp = emp; e.ful = ful;
    exp_q.push_back(e);
  endtask

  // Monitor: one expectation per op, compared 1 time unit after the edge that consumed it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out_valid", 32'(out_valid), 32'(e.ov));
        check("err",       32'(err),       32'(e.er));
        check("data_out",  32'(data_out),  32'(e.dout));
        check("empty",     32'(empty),     32'(e.emp));
        check("full",      32'(full),      32'(e.ful));
      end
    end
  end

  localparam logic [2:0] NOP = 3'd0, PB = 3'd1, PF = 3'd2, POPF = 3'd3, POPB = 3'd4,
                         PKF = 3'd5, PKB = 3'd6, RSV = 3'd7;

  initial begin
    // Reset state
    issue(1, NOP, 0, 8'h00, 0, 0, 8'h00, 2'b11, 2'b00);
    // ch0 FIFO order through the back/front
    issue(0, PB,   0, 8'h11, 0, 0, 8'h00, 2'b10, 2'b00);
    issue(0, PB,   0, 8'h22, 0, 0, 8'h00, 2'b10, 2'b00);
    issue(0, PB,   0, 8'h33, 0, 0, 8'h00, 2'b10, 2'b00);
    issue(0, POPF, 0, 8'h00, 1, 0, 8'h11, 2'b10, 2'b00);
    issue(0, POPF, 0, 8'h00, 1, 0, 8'h22, 2'b10, 2'b00);
    issue(0, POPF, 0, 8'h00, 1, 0, 8'h33, 2'b11, 2'b00);
    issue(0, NOP,  0, 8'h00, 0, 0, 8'h33, 2'b11, 2'b00);
    // ch1 mixed ends, head wraps 0 -> 3 -> 2 and back
    issue(0, PF,   1, 8'hA1, 0, 0, 8'h33, 2'b01, 2'b00);
    issue(0, PF,   1, 8'hA2, 0, 0, 8'h33, 2'b01, 2'b00);
    issue(0, PB,   1, 8'hB1, 0, 0, 8'h33, 2'b01, 2'b00);
    issue(0, POPB, 1, 8'h00, 1, 0, 8'hB1, 2'b01, 2'b00);
    issue(0, POPF, 1, 8'h00, 1, 0, 8'hA2, 2'b01, 2'b00);
    issue(0, POPF, 1, 8'h00, 1, 0, 8'hA1, 2'b11, 2'b00);
    // ch0 fill (pointers start at 3, so this wraps), overflow, drain, underflow
    issue(0, PB,   0, 8'h01, 0, 0, 8'hA1, 2'b10, 2'b00);
    issue(0, PB,   0, 8'h02, 0, 0, 8'hA1, 2'b10, 2'b00);
    issue(0, PB,   0, 8'h03, 0, 0, 8'hA1, 2'b10, 2'b00);
    issue(0, PB,   0, 8'h04, 0, 0, 8'hA1, 2'b10, 2'b01);
    issue(0, PB,   0, 8'hEE, 0, 1, 8'hA1, 2'b10, 2'b01);
    issue(0, PF,   0, 8'hEF, 0, 1, 8'hA1, 2'b10, 2'b01);
    issue(0, POPF, 0, 8'h00, 1, 0, 8'h01, 2'b10, 2'b00);
    issue(0, POPF, 0, 8'h00, 1, 0, 8'h02, 2'b10, 2'b00);
    issue(0, POPB, 0, 8'h00, 1, 0, 8'h04, 2'b10, 2'b00);
    issue(0, POPF, 0, 8'h00, 1, 0, 8'h03, 2'b11, 2'b00);
    issue(0, POPF, 0, 8'h00, 0, 1, 8'h03, 2'b11, 2'b00);
    issue(0, POPB, 1, 8'h00, 0, 1, 8'h03, 2'b11, 2'b00);
    issue(0, NOP,  1, 8'h00, 0, 0, 8'h03, 2'b11, 2'b00);
    // Optional codes, then reset overriding a pop in the same cycle
    issue(0, PB,   1, 8'h55, 0, 0, 8'h03, 2'b01, 2'b00);
`ifdef MULTI_DEQUE_PEEK_EN
    issue(0, PKF,  1, 8'h00, 1, 0, 8'h55, 2'b01, 2'b00);
    issue(0, RSV,  1, 8'h00, 0, 1, 8'h55, 2'b01, 2'b00);
`else
    issue(0, PKF,  1, 8'h00, 0, 1, 8'h03, 2'b01, 2'b00);
    issue(0, RSV,  1, 8'h00, 0, 1, 8'h03, 2'b01, 2'b00);
`endif
    issue(1, POPF, 1, 8'h00, 0, 0, 8'h00, 2'b11, 2'b00);
    // Peek leaves count alone; without the feature peeks are rejected
    issue(0, PB,   0, 8'h10, 0, 0, 8'h00, 2'b10, 2'b00);
    issue(0, PB,   0, 8'h20, 0, 0, 8'h00, 2'b10, 2'b00);
`ifdef MULTI_DEQUE_PEEK_EN
    issue(0, PKF,  0, 8'h00, 1, 0, 8'h10, 2'b10, 2'b00);
    issue(0, PKB,  0, 8'h00, 1, 0, 8'h20, 2'b10, 2'b00);
    issue(0, PKF,  1, 8'h00, 0, 1, 8'h20, 2'b10, 2'b00);
    issue(0, POPF, 0, 8'h00, 1, 0, 8'h10, 2'b10, 2'b00);
`else
    issue(0, PKF,  0, 8'h00, 0, 1, 8'h00, 2'b10, 2'b00);
    issue(0, PKB,  0, 8'h00, 0, 1, 8'h00, 2'b10, 2'b00);
    issue(0, PKF,  1, 8'h00, 0, 1, 8'h00, 2'b10, 2'b00);
    issue(0, POPF, 0, 8'h00, 1, 0, 8'h10, 2'b10, 2'b00);
`endif
    issue(0, POPF, 0, 8'h00, 1, 0, 8'h20, 2'b11, 2'b00);
    issue(0, POPB, 0, 8'h00, 0, 1, 8'h20, 2'b11, 2'b00);

    @(negedge clk);
    op = NOP;
    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
